// File: rtl/clk_int_div_multi.sv
// Multi-channel programmable integer clock divider. Each channel owns a small
// IDLE/RUN/DRAIN FSM and emits a flop-driven, glitch-free divided clock.
module clk_int_div_multi #(
   parameter int NumChannels = 4,
   parameter int DivWidth    = 8,
   parameter int DefaultDiv  = 2
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [NumChannels-1:0]          en_i,
   input  logic [NumChannels*DivWidth-1:0] div_i,
   input  logic [NumChannels-1:0]          div_valid_i,
   output logic [NumChannels-1:0]          div_ready_o,
   output logic [NumChannels-1:0]          clk_o,
   output logic [NumChannels-1:0]          period_start_o,
   output logic [NumChannels-1:0]          busy_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   generate
      for (genvar gi = 0; gi < NumChannels; gi++) begin : g_ch
         state_t              state;
         logic [DivWidth-1:0] cnt;
         logic [DivWidth-1:0] div_q;
         logic                clk_q;
         logic                start_q;

         logic [DivWidth-1:0] div_in;
         logic [DivWidth-1:0] div_clamped;
         logic [DivWidth-1:0] last_cnt;
         logic [DivWidth-1:0] cnt_inc;
         logic [DivWidth:0]   high_len;
         logic                last;
         logic                ready;
         logic                load;

         assign div_in      = div_i[gi*DivWidth +: DivWidth];
         assign div_clamped = (div_in < DivWidth'(2)) ? DivWidth'(2) : div_in;
         assign last_cnt    = div_q - DivWidth'(1);
         assign cnt_inc     = cnt + DivWidth'(1);
         // One extra bit so ceil(d/2) cannot overflow at the maximum divider.
         assign high_len    = ({1'b0, div_q} + {{DivWidth{1'b0}}, 1'b1}) >> 1;

         assign last  = (state != IDLE) && (cnt == last_cnt);
         assign ready = (state == IDLE) || last;
         assign load  = div_valid_i[gi] & ready;

         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               state   <= IDLE;
               cnt     <= '0;
               div_q   <= DivWidth'(DefaultDiv);
               clk_q   <= 1'b0;
               start_q <= 1'b0;
            end else begin
               // A transfer only happens on a period boundary, so the new
               // value governs the period that begins on this same edge.
               if (load) begin
                  div_q <= div_clamped;
               end
               case (state)
                  IDLE: begin
                     cnt <= '0;
                     if (en_i[gi]) begin
                        state   <= RUN;
                        clk_q   <= 1'b1;
                        start_q <= 1'b1;
                     end else begin
                        clk_q   <= 1'b0;
                        start_q <= 1'b0;
                     end
                  end
                  RUN, DRAIN: begin
                     if (last) begin
                        cnt <= '0;
                        if (en_i[gi]) begin
                           state   <= RUN;
                           clk_q   <= 1'b1;
                           start_q <= 1'b1;
                        end else begin
                           state   <= IDLE;
                           clk_q   <= 1'b0;
                           start_q <= 1'b0;
                        end
                     end else begin
                        cnt     <= cnt_inc;
                        clk_q   <= ({1'b0, cnt_inc} < high_len);
                        start_q <= 1'b0;
                        state   <= en_i[gi] ? RUN : DRAIN;
                     end
                  end
                  default: begin
                     state   <= IDLE;
                     cnt     <= '0;
                     clk_q   <= 1'b0;
                     start_q <= 1'b0;
                  end
               endcase
            end
         end

         assign clk_o[gi]          = clk_q;
         assign period_start_o[gi] = start_q;
         assign busy_o[gi]         = (state != IDLE);
         assign div_ready_o[gi]    = ready;
      end
   endgenerate

endmodule

// File: tb/tb_clk_int_div_multi.sv
// Directed self-checking bench for clk_int_div_multi (4 channels, 8-bit dividers).
module tb_clk_int_div_multi;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [3:0]  en_i;
   logic [31:0] div_i;
   logic [3:0]  div_valid_i;
   logic [3:0]  div_ready_o;
   logic [3:0]  clk_o;
   logic [3:0]  period_start_o;
   logic [3:0]  busy_o;

   int tests = 0;
   int fails = 0;

   clk_int_div_multi #(
      .NumChannels (4),
      .DivWidth    (8),
      .DefaultDiv  (2)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .en_i           (en_i),
      .div_i          (div_i),
      .div_valid_i    (div_valid_i),
      .div_ready_o    (div_ready_o),
      .clk_o          (clk_o),
      .period_start_o (period_start_o),
      .busy_o         (busy_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset;
      rst_i = 1'b1;
      en_i = '0;
      div_valid_i = '0;
      div_i = '0;
      #2;
      rst_i = 1'b0;
   endtask

   task automatic test_reset;
      rst_i = 1'b1;
      en_i = 4'hF;
      div_valid_i = '0;
      div_i = '0;
      #3;
      tick;
      tests++;
      if (clk_o !== 4'h0 || period_start_o !== 4'h0 || busy_o !== 4'h0 || div_ready_o !== 4'hF) begin
         fails++;
         $display("FAIL reset_state: clk=%b ps=%b busy=%b rdy=%b, required 0000 0000 0000 1111",
                  clk_o, period_start_o, busy_o, div_ready_o);
      end
      en_i = '0;
      rst_i = 1'b0;
   endtask

   task automatic test_default_div;
      logic e;
      en_i = 4'b0001;
      tick;
      tests++;
      if (clk_o !== 4'b0001 || period_start_o !== 4'b0001 || busy_o !== 4'b0001) begin
         fails++;
         $display("FAIL default_start: clk=%b ps=%b busy=%b, required 0001 0001 0001",
                  clk_o, period_start_o, busy_o);
      end
      for (int i = 1; i <= 6; i++) begin
         tick;
         e = (i % 2 == 0);
         tests++;
         if (clk_o !== {3'b000, e} || period_start_o !== {3'b000, e}) begin
            fails++;
            $display("FAIL default_toggle[%0d]: clk=%b ps=%b, required clk=ps=%b",
                     i, clk_o, period_start_o, {3'b000, e});
         end
      end
      en_i = '0;
      tick;
      tests++;
      if (busy_o[0] !== 1'b1 || clk_o[0] !== 1'b0) begin
         fails++;
         $display("FAIL default_drain: busy=%b clk=%b, required 1 0", busy_o[0], clk_o[0]);
      end
      tick;
      tests++;
      if (busy_o[0] !== 1'b0 || clk_o[0] !== 1'b0 || div_ready_o[0] !== 1'b1) begin
         fails++;
         $display("FAIL default_idle: busy=%b clk=%b rdy=%b, required 0 0 1",
                  busy_o[0], clk_o[0], div_ready_o[0]);
      end
      do_reset;
   endtask

   task automatic test_div5;
      int c;
      logic ec, ep, er;
      div_i[15:8] = 8'd5;
      div_valid_i = 4'b0010;
      en_i = 4'b0010;
      tests++;
      if (div_ready_o !== 4'hF) begin
         fails++;
         $display("FAIL div5_idle_ready: rdy=%b, required 1111", div_ready_o);
      end
      tick;
      div_valid_i = '0;
      tests++;
      if (clk_o[1] !== 1'b1 || period_start_o[1] !== 1'b1 || div_ready_o[1] !== 1'b0) begin
         fails++;
         $display("FAIL div5_start: clk=%b ps=%b rdy=%b, required 1 1 0",
                  clk_o[1], period_start_o[1], div_ready_o[1]);
      end
      for (int i = 1; i <= 10; i++) begin
         tick;
         c = i % 5;
         ec = (c < 3);
         ep = (c == 0);
         er = (c == 4);
         tests++;
         if (clk_o[1] !== ec || period_start_o[1] !== ep || div_ready_o[1] !== er || clk_o[0] !== 1'b0) begin
            fails++;
            $display("FAIL div5_cycle[%0d]: clk=%b ps=%b rdy=%b ch0=%b, required %b %b %b 0",
                     i, clk_o[1], period_start_o[1], div_ready_o[1], clk_o[0], ec, ep, er);
         end
      end
      do_reset;
   endtask

   task automatic test_update_at_boundary;
      int c;
      logic ec, ep, er;
      div_i[23:16] = 8'd4;
      div_valid_i = 4'b0100;
      en_i = 4'b0100;
      tick;
      div_valid_i = '0;
      tick;
      tests++;
      if (clk_o[2] !== 1'b1 || div_ready_o[2] !== 1'b0) begin
         fails++;
         $display("FAIL upd_cnt1: clk=%b rdy=%b, required 1 0", clk_o[2], div_ready_o[2]);
      end
      div_i[23:16] = 8'd6;
      div_valid_i = 4'b0100;
      tick;
      tests++;
      if (clk_o[2] !== 1'b0 || div_ready_o[2] !== 1'b0 || period_start_o[2] !== 1'b0) begin
         fails++;
         $display("FAIL upd_cnt2: clk=%b rdy=%b ps=%b, required 0 0 0",
                  clk_o[2], div_ready_o[2], period_start_o[2]);
      end
      tick;
      tests++;
      if (clk_o[2] !== 1'b0 || div_ready_o[2] !== 1'b1) begin
         fails++;
         $display("FAIL upd_cnt3: clk=%b rdy=%b, required 0 1", clk_o[2], div_ready_o[2]);
      end
      tick;
      div_valid_i = '0;
      tests++;
      if (clk_o[2] !== 1'b1 || period_start_o[2] !== 1'b1 || div_ready_o[2] !== 1'b0) begin
         fails++;
         $display("FAIL upd_new_start: clk=%b ps=%b rdy=%b, required 1 1 0",
                  clk_o[2], period_start_o[2], div_ready_o[2]);
      end
      for (int i = 1; i <= 6; i++) begin
         tick;
         c = i % 6;
         ec = (c < 3);
         ep = (c == 0);
         er = (c == 5);
         tests++;
         if (clk_o[2] !== ec || period_start_o[2] !== ep || div_ready_o[2] !== er) begin
            fails++;
            $display("FAIL upd_d6_cycle[%0d]: clk=%b ps=%b rdy=%b, required %b %b %b",
                     i, clk_o[2], period_start_o[2], div_ready_o[2], ec, ep, er);
         end
      end
      do_reset;
   endtask

   task automatic test_drain;
      bit ec [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      bit eb [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      int c;
      logic xc, xp;
      div_i[31:24] = 8'd6;
      div_valid_i = 4'b1000;
      en_i = 4'b1000;
      tick;
      div_valid_i = '0;
      tick;
      en_i = '0;
      for (int i = 0; i < 5; i++) begin
         tick;
         tests++;
         if (clk_o[3] !== ec[i] || busy_o[3] !== eb[i] || period_start_o[3] !== 1'b0) begin
            fails++;
            $display("FAIL drain_cycle[%0d]: clk=%b busy=%b ps=%b, required %b %b 0",
                     i, clk_o[3], busy_o[3], period_start_o[3], ec[i], eb[i]);
         end
      end
      en_i = 4'b1000;
      tick;
      tests++;
      if (clk_o[3] !== 1'b1 || period_start_o[3] !== 1'b1) begin
         fails++;
         $display("FAIL drain_restart: clk=%b ps=%b, required 1 1", clk_o[3], period_start_o[3]);
      end
      for (int i = 1; i <= 7; i++) begin
         tick;
         c = i % 6;
         xc = (c < 3);
         xp = (c == 0);
         tests++;
         if (clk_o[3] !== xc || period_start_o[3] !== xp || busy_o[3] !== 1'b1) begin
            fails++;
            $display("FAIL drain_reenable[%0d]: clk=%b ps=%b busy=%b, required %b %b 1",
                     i, clk_o[3], period_start_o[3], busy_o[3], xc, xp);
         end
         if (i == 1) en_i = '0;
         if (i == 3) en_i = 4'b1000;
      end
      do_reset;
   endtask

   task automatic test_clamp_and_max;
      logic [7:0] vals [2] = '{8'd0, 8'd1};
      logic e;
      int hi;
      int lo;
      int guard;
      for (int v = 0; v < 2; v++) begin
         div_i[7:0] = vals[v];
         div_valid_i = 4'b0001;
         en_i = 4'b0001;
         tick;
         div_valid_i = '0;
         for (int i = 0; i < 5; i++) begin
            e = (i % 2 == 0);
            tests++;
            if (clk_o[0] !== e || period_start_o[0] !== e) begin
               fails++;
               $display("FAIL clamp_div%0d[%0d]: clk=%b ps=%b, required %b %b",
                        vals[v], i, clk_o[0], period_start_o[0], e, e);
            end
            tick;
         end
         do_reset;
      end
      div_i[7:0] = 8'd255;
      div_valid_i = 4'b0001;
      en_i = 4'b0001;
      tick;
      div_valid_i = '0;
      hi = 0;
      lo = 0;
      guard = 0;
      while (clk_o[0] === 1'b1 && guard < 600) begin
         hi++;
         tick;
         guard++;
      end
      while (clk_o[0] === 1'b0 && period_start_o[0] === 1'b0 && guard < 600) begin
         lo++;
         tick;
         guard++;
      end
      tests++;
      if (hi != 128 || lo != 127) begin
         fails++;
         $display("FAIL max_div_duty: high=%0d low=%0d, required 128 127", hi, lo);
      end
      tests++;
      if (clk_o[0] !== 1'b1 || period_start_o[0] !== 1'b1) begin
         fails++;
         $display("FAIL max_div_next_period: clk=%b ps=%b, required 1 1", clk_o[0], period_start_o[0]);
      end
      do_reset;
   endtask

   task automatic test_reset_mid;
      div_i = {8'd6, 8'd5, 8'd4, 8'd3};
      div_valid_i = 4'hF;
      en_i = 4'hF;
      tick;
      div_valid_i = '0;
      tick;
      tests++;
      if (clk_o !== 4'hF) begin
         fails++;
         $display("FAIL rstmid_high: clk=%b, required 1111", clk_o);
      end
      #3;
      rst_i = 1'b1;
      #1;
      tests++;
      if (clk_o !== 4'h0 || busy_o !== 4'h0 || period_start_o !== 4'h0 || div_ready_o !== 4'hF) begin
         fails++;
         $display("FAIL rstmid_async: clk=%b busy=%b ps=%b rdy=%b, required 0000 0000 0000 1111",
                  clk_o, busy_o, period_start_o, div_ready_o);
      end
      rst_i = 1'b0;
      tick;
      tests++;
      if (clk_o !== 4'hF || period_start_o !== 4'hF || busy_o !== 4'hF) begin
         fails++;
         $display("FAIL rstmid_restart: clk=%b ps=%b busy=%b, required 1111 1111 1111",
                  clk_o, period_start_o, busy_o);
      end
      tick;
      tests++;
      if (clk_o !== 4'h0 || div_ready_o !== 4'hF) begin
         fails++;
         $display("FAIL rstmid_default_low: clk=%b rdy=%b, required 0000 1111", clk_o, div_ready_o);
      end
      tick;
      tests++;
      if (clk_o !== 4'hF || period_start_o !== 4'hF) begin
         fails++;
         $display("FAIL rstmid_default_period: clk=%b ps=%b, required 1111 1111", clk_o, period_start_o);
      end
      do_reset;
   endtask

   initial begin
      test_reset;
      test_default_div;
      test_div5;
      test_update_at_boundary;
      test_drain;
      test_clamp_and_max;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
